// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues one memory request at a time and
// feeds the IF/ID register, with decode stall, redirect flush and a one-entry buffer.
module fetch_stage #(
  parameter int unsigned      XLEN      = 32,
  parameter logic [XLEN-1:0]  RESET_PC  = '0,
  parameter logic [31:0]      NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            stall,
  output logic            if_id_valid,
  output logic [XLEN-1:0] if_id_pc,
  output logic [XLEN-1:0] if_id_pc_plus4,
  output logic [31:0]     if_id_instr,
  output logic [6:0]      if_id_opcode
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_WAIT,
    S_HOLD
  } state_t;

  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(3));

  state_t          r_state;
  state_t          w_state_nxt;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_nxt;
  logic            r_drop;
  logic            w_drop_nxt;
  logic            r_buf_valid;
  logic            w_buf_valid_nxt;
  logic [31:0]     r_buf_instr;
  logic [XLEN-1:0] r_buf_pc;

  logic            r_if_valid;
  logic [XLEN-1:0] r_if_pc;
  logic [XLEN-1:0] r_if_pc4;
  logic [31:0]     r_if_instr;

  logic            w_req_valid;
  logic            w_hs;
  logic            w_slot_free;
  logic [XLEN-1:0] w_pc_plus4;
  logic [XLEN-1:0] w_redirect_target;
  logic            w_buf_load;
  logic            w_if_load;
  logic            w_if_from_buf;
  logic            w_flush;
  logic [31:0]     w_if_instr_src;
  logic [XLEN-1:0] w_if_pc_src;

  assign w_req_valid       = (r_state == S_FETCH) && !rst;
  assign w_hs              = w_req_valid && imem_req_ready;
  assign w_slot_free       = !(r_if_valid && stall);
  assign w_pc_plus4        = r_pc + PC_STEP;
  assign w_redirect_target = redirect_pc & ALIGN_MASK;
  assign w_if_instr_src    = w_if_from_buf ? r_buf_instr : imem_rsp_data;
  assign w_if_pc_src       = w_if_from_buf ? r_buf_pc : r_pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_FETCH;
      r_pc        <= RESET_PC;
      r_drop      <= 1'b0;
      r_buf_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_drop      <= w_drop_nxt;
      r_buf_valid <= w_buf_valid_nxt;
    end
  end

  // Redirect outranks stall and any response; drop marks the one stale response still owed.
  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_drop_nxt      = r_drop;
    w_buf_valid_nxt = r_buf_valid;
    w_buf_load      = 1'b0;
    w_if_load       = 1'b0;
    w_if_from_buf   = 1'b0;
    w_flush         = 1'b0;
    if (redirect_valid) begin
      w_flush         = 1'b1;
      w_pc_nxt        = w_redirect_target;
      w_buf_valid_nxt = 1'b0;
      unique case (r_state)
        S_FETCH: begin
          if (w_hs) begin
            w_drop_nxt  = 1'b1;
            w_state_nxt = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            w_drop_nxt  = 1'b0;
            w_state_nxt = S_FETCH;
          end else begin
            w_drop_nxt  = 1'b1;
          end
        end
        S_HOLD:  w_state_nxt = S_FETCH;
        default: w_state_nxt = S_FETCH;
      endcase
    end else begin
      unique case (r_state)
        S_FETCH: begin
          if (w_hs) w_state_nxt = S_WAIT;
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            if (r_drop) begin
              w_drop_nxt  = 1'b0;
              w_state_nxt = S_FETCH;
            end else if (w_slot_free) begin
              w_if_load   = 1'b1;
              w_pc_nxt    = w_pc_plus4;
              w_state_nxt = S_FETCH;
            end else begin
              w_buf_load      = 1'b1;
              w_buf_valid_nxt = 1'b1;
              w_pc_nxt        = w_pc_plus4;
              w_state_nxt     = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (!stall) begin
            w_if_load       = 1'b1;
            w_if_from_buf   = 1'b1;
            w_buf_valid_nxt = 1'b0;
            w_state_nxt     = S_FETCH;
          end
        end
        default: w_state_nxt = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buf_instr <= '0;
      r_buf_pc    <= '0;
    end else if (w_buf_load) begin
      r_buf_instr <= imem_rsp_data;
      r_buf_pc    <= r_pc;
    end
  end

  // A stalled valid instruction holds; any other cycle without a load leaves a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_if_valid <= 1'b0;
      r_if_pc    <= '0;
      r_if_pc4   <= '0;
      r_if_instr <= NOP_INSTR;
    end else if (w_flush) begin
      r_if_valid <= 1'b0;
      r_if_instr <= NOP_INSTR;
    end else if (w_if_load) begin
      r_if_valid <= 1'b1;
      r_if_pc    <= w_if_pc_src;
      r_if_pc4   <= w_if_pc_src + PC_STEP;
      r_if_instr <= w_if_instr_src;
    end else if (w_slot_free) begin
      r_if_valid <= 1'b0;
      r_if_instr <= NOP_INSTR;
    end
  end

  assign imem_req_valid = w_req_valid;
  assign imem_req_addr  = r_pc;
  assign if_id_valid    = r_if_valid;
  assign if_id_pc       = r_if_pc;
  assign if_id_pc_plus4 = r_if_pc4;
  assign if_id_instr    = r_if_instr;
  assign if_id_opcode   = r_if_instr[6:0];

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus randomized traffic checked against
// a program-order model (expected PC stream) and a behavioural instruction memory.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc_plus4;
  logic [31:0] if_id_instr;
  logic [6:0]  if_id_opcode;

  int n_checks = 0;
  int n_errors = 0;

  bit          mem_busy;
  logic [31:0] mem_addr;
  int          mem_left;
  int          mem_lat;
  logic [31:0] exp_pc;
  int          delivered;

  always #5 clk = ~clk;

  fetch_stage #(
    .XLEN      (32),
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (32'h0000_0013)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .if_id_valid    (if_id_valid),
    .if_id_pc       (if_id_pc),
    .if_id_pc_plus4 (if_id_pc_plus4),
    .if_id_instr    (if_id_instr),
    .if_id_opcode   (if_id_opcode)
  );

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    if (a == 32'h0)      return 32'h00A0_0093;
    else if (a == 32'h4) return 32'h0010_8113;
    else                 return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: memory model, program-order model and invariants, sampled at the negedge.
  task automatic step();
    logic        hs, rsp, redir, hold, rv_prev, rdy;
    logic [31:0] addr_prev, rpc_prev, pc_prev, instr_prev, pc4_prev, ei;
    hs         = imem_req_valid && imem_req_ready;
    rsp        = imem_rsp_valid;
    redir      = redirect_valid;
    rpc_prev   = redirect_pc;
    hold       = if_id_valid && stall && !redirect_valid;
    rv_prev    = imem_req_valid;
    rdy        = imem_req_ready;
    addr_prev  = imem_req_addr;
    pc_prev    = if_id_pc;
    instr_prev = if_id_instr;
    pc4_prev   = if_id_pc_plus4;
    if (hs) check_eq("one_outstanding", 32'(mem_busy), 32'd0);
    @(posedge clk);
    @(negedge clk);
    if (rsp) mem_busy = 1'b0;
    if (hs) begin
      mem_busy = 1'b1;
      mem_addr = addr_prev;
      mem_left = mem_lat;
    end else if (mem_busy && mem_left > 0) begin
      mem_left--;
    end
    imem_rsp_valid = mem_busy && (mem_left == 0);
    imem_rsp_data  = mem_busy ? instr_of(mem_addr) : $urandom;
    if (!rst) begin
      if (redir) begin
        exp_pc = rpc_prev & 32'hFFFF_FFFC;
        check_eq("flush_valid", 32'(if_id_valid), 32'd0);
      end else if (hold) begin
        check_eq("hold_valid", 32'(if_id_valid), 32'd1);
        check_eq("hold_pc", if_id_pc, pc_prev);
        check_eq("hold_pc4", if_id_pc_plus4, pc4_prev);
        check_eq("hold_instr", if_id_instr, instr_prev);
      end else if (if_id_valid) begin
        ei = instr_of(exp_pc);
        check_eq("order_pc", if_id_pc, exp_pc);
        check_eq("order_instr", if_id_instr, ei);
        check_eq("order_pc4", if_id_pc_plus4, exp_pc + 32'd4);
        check_eq("order_opcode", 32'(if_id_opcode), 32'(ei[6:0]));
        exp_pc = exp_pc + 32'd4;
        delivered++;
      end
      if (!if_id_valid) check_eq("bubble_nop", if_id_instr, NOP);
      if (rv_prev && !rdy && !redir) begin
        check_eq("req_held_valid", 32'(imem_req_valid), 32'd1);
        check_eq("req_held_addr", imem_req_addr, addr_prev);
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
    check_eq({tag, "_if_valid"}, 32'(if_id_valid), 32'd0);
    check_eq({tag, "_if_pc"}, if_id_pc, 32'd0);
    check_eq({tag, "_if_pc4"}, if_id_pc_plus4, 32'd0);
    check_eq({tag, "_if_instr"}, if_id_instr, NOP);
    check_eq({tag, "_opcode"}, 32'(if_id_opcode), 32'h13);
  endtask

  initial begin
    rst = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; stall = 1'b0;
    mem_busy = 1'b0; mem_addr = '0; mem_left = 0; mem_lat = 0; exp_pc = '0; delivered = 0;
    #1;
    check_reset_outputs("rst0");
    repeat (2) @(negedge clk);
    check_eq("rst_req_low", 32'(imem_req_valid), 32'd0);
    rst = 1'b0;
    #1;
    check_eq("rel_req_valid", 32'(imem_req_valid), 32'd1);
    check_eq("rel_req_addr", imem_req_addr, 32'h0);

    // Straight-line fetch with a 1-cycle memory
    imem_req_ready = 1'b1;
    step();
    check_eq("t1_wait_req", 32'(imem_req_valid), 32'd0);
    check_eq("t1_wait_if", 32'(if_id_valid), 32'd0);
    step();
    check_eq("t1_v0", 32'(if_id_valid), 32'd1);
    check_eq("t1_pc0", if_id_pc, 32'h0);
    check_eq("t1_pc4_0", if_id_pc_plus4, 32'h4);
    check_eq("t1_instr0", if_id_instr, 32'h00A0_0093);
    check_eq("t1_op0", 32'(if_id_opcode), 32'h13);
    check_eq("t1_addr4", imem_req_addr, 32'h4);
    step();
    check_eq("t1_bubble", 32'(if_id_valid), 32'd0);
    step();
    check_eq("t1_v1", 32'(if_id_valid), 32'd1);
    check_eq("t1_pc1", if_id_pc, 32'h4);
    check_eq("t1_pc4_1", if_id_pc_plus4, 32'h8);
    check_eq("t1_instr1", if_id_instr, 32'h0010_8113);

    // Memory not ready while decode stalls on pc 0x4
    stall = 1'b1;
    imem_req_ready = 1'b0;
    for (int unsigned i = 0; i < 5; i++) begin
      step();
      check_eq("t2_req_valid", 32'(imem_req_valid), 32'd1);
      check_eq("t2_req_addr", imem_req_addr, 32'h8);
      check_eq("t2_if_pc", if_id_pc, 32'h4);
    end

    // Response for 0x8 arrives under stall -> buffered in HOLD
    imem_req_ready = 1'b1;
    step();
    check_eq("t3_wait_req", 32'(imem_req_valid), 32'd0);
    step();
    check_eq("t3_hold_req", 32'(imem_req_valid), 32'd0);
    check_eq("t3_hold_pc", if_id_pc, 32'h4);
    step();
    check_eq("t3_hold_req2", 32'(imem_req_valid), 32'd0);
    stall = 1'b0;
    step();
    check_eq("t3_rel_valid", 32'(if_id_valid), 32'd1);
    check_eq("t3_rel_pc", if_id_pc, 32'h8);
    check_eq("t3_next_req", 32'(imem_req_valid), 32'd1);
    check_eq("t3_next_addr", imem_req_addr, 32'hC);

    // Redirect while the request for 0x10 is in flight
    step();
    step();
    check_eq("t4_pcC", if_id_pc, 32'hC);
    check_eq("t4_addr10", imem_req_addr, 32'h10);
    mem_lat = 2;
    step();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0103;
    step();
    redirect_valid = 1'b0;
    check_eq("t4_flush_instr", if_id_instr, NOP);
    check_eq("t4_wait_req", 32'(imem_req_valid), 32'd0);
    step();
    check_eq("t4_wait_req2", 32'(imem_req_valid), 32'd0);
    step();
    check_eq("t4_refetch_req", 32'(imem_req_valid), 32'd1);
    check_eq("t4_refetch_addr", imem_req_addr, 32'h100);
    check_eq("t4_no_if", 32'(if_id_valid), 32'd0);
    mem_lat = 0;
    step();
    step();
    check_eq("t4_pc100", if_id_pc, 32'h100);

    // Redirect + stall in the same cycle as a response
    stall = 1'b1;
    step();
    check_eq("t5_held_pc", if_id_pc, 32'h100);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0200;
    step();
    redirect_valid = 1'b0;
    check_eq("t5_valid", 32'(if_id_valid), 32'd0);
    check_eq("t5_instr", if_id_instr, NOP);
    check_eq("t5_req_valid", 32'(imem_req_valid), 32'd1);
    check_eq("t5_req_addr", imem_req_addr, 32'h200);
    step();
    step();
    check_eq("t5_load_valid", 32'(if_id_valid), 32'd1);
    check_eq("t5_load_pc", if_id_pc, 32'h200);
    stall = 1'b0;

    // Asynchronous reset in WAIT
    mem_lat = 3;
    step();
    check_eq("t6_in_wait", 32'(imem_req_valid), 32'd0);
    rst = 1'b1;
    mem_busy = 1'b0;
    imem_rsp_valid = 1'b0;
    exp_pc = 32'h0;
    #1;
    check_reset_outputs("t6");
    step();
    rst = 1'b0;
    mem_lat = 0;
    #1;
    check_eq("t6_req_valid", 32'(imem_req_valid), 32'd1);
    check_eq("t6_req_addr", imem_req_addr, 32'h0);

    // Redirect to the top of the address space; PC wraps after that fetch
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFF;
    step();
    redirect_valid = 1'b0;
    check_eq("t7_addr_top", imem_req_addr, 32'hFFFF_FFFC);
    imem_req_ready = 1'b1;
    step();
    step();
    check_eq("t7_pc_top", if_id_pc, 32'hFFFF_FFFC);
    check_eq("t7_pc4_wrap", if_id_pc_plus4, 32'h0);
    check_eq("t7_addr_wrap", imem_req_addr, 32'h0);

    // Randomized traffic
    delivered = 0;
    for (int unsigned i = 0; i < 3000; i++) begin
      imem_req_ready = ($urandom_range(0, 3) != 0);
      stall          = ($urandom_range(0, 9) < 3);
      redirect_valid = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 3) == 0) redirect_pc = 32'hFFFF_FFF0 | ($urandom % 16);
      else                           redirect_pc = $urandom;
      mem_lat = $urandom_range(0, 3);
      step();
    end
    redirect_valid = 1'b0;
    check_eq("rand_throughput", 32'(delivered > 100), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage. Holds the PC and issues one instruction-memory request at a time.
- Captures the response into the IF/ID register, which drives the opcode into the main decoder/control unit directly downstream.
- Supports decode stall, branch/jump redirect with in-flight response drop, and a one-entry buffer for responses that arrive while decode is stalled.

Parameters:
- XLEN, 32, datapath/address width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, instruction presented on IF/ID when invalid (ADDI x0,x0,0).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts request this cycle.
- imem_req_addr  output  XLEN  fetch address (= PC register).
- imem_rsp_valid  input  1  response data valid; no back-pressure is possible.
- imem_rsp_data  input  32  fetched instruction.
- redirect_valid  input  1  branch/jump taken; flush and refetch.
- redirect_pc  input  XLEN  target; bits [1:0] forced to 0 internally.
- stall  input  1  decode cannot accept; hold IF/ID.
- if_id_valid  output  1  IF/ID holds a real instruction.
- if_id_pc  output  XLEN  PC of the IF/ID instruction.
- if_id_pc_plus4  output  XLEN  if_id_pc + 4, used as the JAL/JALR link value.
- if_id_instr  output  32  instruction.
- if_id_opcode  output  7  if_id_instr[6:0], the control-unit input.

Behaviour:
- Reset (async, any time, including mid-request): pc=RESET_PC, state=FETCH, drop=0, buf_valid=0, if_id_valid=0, if_id_pc=0, if_id_pc_plus4=0, if_id_instr=NOP_INSTR.
  - imem_req_valid=0 while rst is high.
  - The memory shares rst, so no stale response survives reset.
- FSM states: FETCH, WAIT, HOLD. At most one outstanding request.
- FETCH:
  - imem_req_valid=1, imem_req_addr=pc; the address is stable until accepted.
  - On valid&&ready, go to WAIT.
- WAIT:
  - imem_req_valid=0. Await imem_rsp_valid; minimum latency is 1 cycle after acceptance.
  - On response with drop=1: discard it, clear drop, go to FETCH.
  - On response with drop=0 and the IF/ID slot free: load IF/ID at the next edge, pc<=pc+4, go to FETCH.
  - The slot is free when !(if_id_valid && stall).
  - On response with drop=0 and the slot busy: store data and pc in the buffer (buf_valid=1), pc<=pc+4, go to HOLD.
- HOLD:
  - imem_req_valid=0. When stall deasserts, move the buffer to IF/ID, clear buf_valid, go to FETCH.
- IF/ID update: if_id_valid && stall holds all outputs unchanged. If stall=0 and nothing is loaded that edge, if_id_valid<=0 and if_id_instr<=NOP_INSTR.
- Throughput: at best one instruction per 2 cycles (request cycle + response cycle).
- Arithmetic: pc+4 is modulo 2^XLEN; 0xFFFF_FFFC wraps to 0x0000_0000 silently.
- redirect_valid has priority over stall and over any response in the same cycle. It has these effects at the next edge:
  - pc<=redirect_pc&~3.
  - IF/ID flushed: if_id_valid=0, instr=NOP_INSTR.
  - buf_valid=0.
  - In WAIT with no response this cycle: drop<=1, stay in WAIT.
  - In WAIT with a response this cycle: the response is discarded, go to FETCH.
  - In FETCH with the handshake completing this cycle: the old-address request is in flight, so drop<=1, go to WAIT.
  - In FETCH without a handshake: stay in FETCH; the new address appears on the next cycle.
  - In HOLD: go to FETCH.
- Back-to-back redirects: the last one wins. drop stays 1 until exactly one response is discarded.
- stall with if_id_valid=0 has no effect; a bubble can be overwritten.

Test Plan:
- Release reset with RESET_PC=0 and 1-cycle memory returning 0x00A00093, 0x00108113 → if_id_pc 0x0, then 0x4; if_id_opcode=7'b0010011; if_id_pc_plus4=0x4, then 0x8; if_id_valid pulses valid every 2 cycles.
- Hold imem_req_ready=0 for 5 cycles in FETCH → imem_req_valid stays 1 with imem_req_addr constant at 0x8; no IF/ID change.
- stall=1 while IF/ID holds pc 0x4 and the response for 0x8 arrives → IF/ID stays at 0x4 and the FSM enters HOLD. Release stall → IF/ID shows pc 0x8 next cycle; the next request is to 0xC.
- redirect_valid=1 with redirect_pc=0x103 in the cycle after the request for 0x10 is accepted; response arrives 2 cycles later → response discarded, next request addr 0x100, no IF/ID output for 0x10.
- redirect_valid=1 and stall=1 in the same cycle as a response → if_id_valid=0, if_id_instr=0x00000013, buffer empty, next request is the redirect target.
- Assert rst during WAIT → all outputs return to reset values immediately. After release the first request is to RESET_PC.
- Redirect to 0xFFFF_FFFC → pc wraps to 0x0 after that fetch.
